gpio_irq_ctrl: RTL and testbench

//  Input-side companion of the GPIO peripheral. Consumes the pad read-back vector.
//  Per bit it synchronises, debounces and edge-detects the vector.

---
 rtl/gpio_pkg.sv | 23 ++
 rtl/gpio_debounce.sv | 64 ++++++
 rtl/gpio_irq_ctrl.sv | 125 ++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map and debounce state for the GPIO input block
// Purpose: register byte offsets of the input-side register window and the
//          per-bit synchroniser/debounce state record.
// Ports:   none (package)
package gpio_pkg;

  localparam logic [7:0] OFF_LEVEL    = 8'h00;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h04;
  localparam logic [7:0] OFF_RISE_EN  = 8'h08;
  localparam logic [7:0] OFF_FALL_EN  = 8'h0C;
  localparam logic [7:0] OFF_PENDING  = 8'h10;
  localparam logic [7:0] OFF_DB_LIMIT = 8'h14;

  // Per-bit pipeline: two synchroniser stages plus the debounced level.
  typedef struct packed {
    logic s1;
    logic s2;
    logic stable;
  } db_state_t;

  localparam db_state_t DB_STATE_RST = '0;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one-bit synchroniser, debouncer and edge detector
// Purpose: synchronises one asynchronous pad bit, accepts a new level only after
//          it disagrees with the current stable level for limit_i+1 edges, and
//          reports the rise/fall that the next clock edge will commit.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pad_i       asynchronous pad level
//   limit_i     debounce limit (0 = bypass)
//   clr_i       restart any in-progress qualification
//   stable_o    debounced level
//   rise_o      stable goes 0->1 on the coming edge
//   fall_o      stable goes 1->0 on the coming edge
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             clr_i,
  output logic             stable_o,
  output logic             rise_o,
  output logic             fall_o
);

  db_state_t        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    st_d.s1 = pad_i;
    st_d.s2 = st_q.s1;
    if (clr_i) begin
      // A limit rewrite restarts qualification; no level is accepted this edge.
      cnt_d = '0;
    end else if (st_q.s2 == st_q.stable) begin
      cnt_d = '0;
    end else if (cnt_q >= limit_i) begin
      // >= also stops a counter that ran past a lowered limit, so it never wraps.
      st_d.stable = st_q.s2;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= DB_STATE_RST;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable_o = st_q.stable;
  assign rise_o   = st_d.stable & ~st_q.stable;
  assign fall_o   = ~st_d.stable & st_q.stable;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO input debounce, edge capture and interrupt controller
// Purpose: per-bit synchronise/debounce/edge-detect of gpio_in, W1C pending
//          register, level interrupt, zero-wait-state Wishbone register window.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i          Wishbone control
//   addr_i, data_i              byte address ([7:0] decoded), write data
//   data_o, ack_o               read data, combinational acknowledge
//   gpio_in                     asynchronous pad levels
//   irq_o                       level interrupt, active high
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int CNT_W     = 16,
  parameter int LIMIT_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] LIMIT_RST_V = LIMIT_RST[CNT_W-1:0];

  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] db_limit_q, db_limit_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] level, rise, fall, w1c_mask;
  logic             db_clr, wr_en, rd_en;
  logic [7:0]       off;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign off         = addr_i[7:0];
  assign wr_en       = cyc_i & stb_i & we_i;
  assign rd_en       = cyc_i & stb_i & ~we_i;
  assign ack_o       = cyc_i & stb_i;
  assign unused_bits = ^{addr_i[31:8], data_i};

  gpio_debounce #(.CNT_W(CNT_W)) u_db [WIDTH-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad_i    (gpio_in),
    .limit_i  (db_limit_q),
    .clr_i    (db_clr),
    .stable_o (level),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_comb begin
    irq_en_d   = irq_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    db_limit_d = db_limit_q;
    w1c_mask   = '0;
    db_clr     = 1'b0;
    if (wr_en) begin
      case (off)
        OFF_IRQ_EN:   irq_en_d  = data_i[WIDTH-1:0];
        OFF_RISE_EN:  rise_en_d = data_i[WIDTH-1:0];
        OFF_FALL_EN:  fall_en_d = data_i[WIDTH-1:0];
        OFF_PENDING:  w1c_mask  = data_i[WIDTH-1:0];
        OFF_DB_LIMIT: begin
          db_limit_d = data_i[CNT_W-1:0];
          db_clr     = 1'b1;
        end
        default: ;
      endcase
    end
    // Set terms are OR-ed after the clear so a same-edge event survives its W1C.
    pending_d = (pending_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    // Registered so irq_o is a single flop output and follows PENDING on the same edge.
    irq_d     = |(pending_d & irq_en_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pending_q  <= '0;
      db_limit_q <= LIMIT_RST_V;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pending_q  <= pending_d;
      db_limit_q <= db_limit_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (off)
        OFF_LEVEL:    rdata[WIDTH-1:0] = level;
        OFF_IRQ_EN:   rdata[WIDTH-1:0] = irq_en_q;
        OFF_RISE_EN:  rdata[WIDTH-1:0] = rise_en_q;
        OFF_FALL_EN:  rdata[WIDTH-1:0] = fall_en_q;
        OFF_PENDING:  rdata[WIDTH-1:0] = pending_q;
        OFF_DB_LIMIT: rdata[CNT_W-1:0] = db_limit_q;
        default: ;
      endcase
    end
  end

  assign data_o = rdata;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - self-checking bench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

  localparam int W  = 20;
  localparam int CW = 16;
  localparam int LR = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   data_o;
  logic          ack_o;
  logic [W-1:0]  gpio_in = '0;
  logic          irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_irq_ctrl #(.WIDTH(W), .CNT_W(CW), .LIMIT_RST(LR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (data_o),
    .ack_o   (ack_o),
    .gpio_in (gpio_in),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits k rising edges, then moves 1ns past the last one.
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = {24'h0, a}; wdata = d;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {24'h0, a};
    #1;
    d = data_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic do_reset();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; gpio_in = '0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  // Behavioural reference: bit vectors for registers, and per bit the length of
  // the current run of edges on which the synchronised pad disagreed with the
  // accepted level. A level is accepted on the (limit+1)-th disagreeing edge.
  logic [W-1:0] m_in1, m_in2, m_stable, m_pend, m_ien, m_ren, m_fen;
  int           m_run [W];
  int           m_limit;
  logic         m_irq;

  task automatic model_reset();
    m_in1 = '0; m_in2 = '0; m_stable = '0; m_pend = '0;
    m_ien = '0; m_ren = '0; m_fen = '0; m_irq = 1'b0;
    m_limit = LR;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_step(input logic [W-1:0] pad, input bit wr,
                            input logic [7:0] a, input logic [31:0] d);
    logic [W-1:0] seen, nst, w1c;
    bit clr;
    seen = m_in2;   // synchroniser output = pad two edges back
    nst  = m_stable;
    w1c  = '0;
    clr  = wr && (a == 8'h14);
    for (int i = 0; i < W; i++) begin
      if (clr || seen[i] == m_stable[i]) m_run[i] = 0;
      else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > m_limit) begin
          nst[i]   = seen[i];
          m_run[i] = 0;
        end
      end
    end
    if (wr && a == 8'h10) w1c = d[W-1:0];
    m_pend = (m_pend & ~w1c) | (nst & ~m_stable & m_ren) | (~nst & m_stable & m_fen);
    if (wr) begin
      case (a)
        8'h04: m_ien = d[W-1:0];
        8'h08: m_ren = d[W-1:0];
        8'h0C: m_fen = d[W-1:0];
        8'h14: m_limit = int'(d[CW-1:0]);
        default: ;
      endcase
    end
    m_irq    = |(m_pend & m_ien);
    m_stable = nst;
    m_in2    = m_in1;
    m_in1    = pad;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  initial begin
    logic [31:0] v;
    logic [W-1:0] pad;

    vecs[0] = '{8'h04, 32'hFFFF_FFFF, 32'h000F_FFFF};
    vecs[1] = '{8'h08, 32'h0001_2345, 32'h0001_2345};
    vecs[2] = '{8'h0C, 32'hFFFA_BCDE, 32'h000A_BCDE};
    vecs[3] = '{8'h14, 32'h1234_5678, 32'h0000_5678};
    vecs[4] = '{8'h00, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{8'h18, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{8'h10, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{8'h01, 32'hFFFF_FFFF, 32'h0000_0000};

    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Register access table
    for (int i = 0; i < 8; i++) begin
      bus_wr(vecs[i].a, vecs[i].d);
      rd_chk($sformatf("reg_rw_%0h", vecs[i].a), vecs[i].a, vecs[i].exp);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0; #1;
    chk("ack_write", {31'h0, ack_o}, 32'h1);
    chk("data_o_idle_on_write", data_o, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; #1;
    chk("ack_idle", {31'h0, ack_o}, 32'h0);

    // Reset in the middle of a bus cycle with irq_o asserted
    bus_wr(8'h14, 32'h0);
    bus_wr(8'h08, 32'h1);
    bus_wr(8'h04, 32'h1);
    gpio_in[0] = 1'b1;
    tick(4);
    chk("rst_pre_irq", {31'h0, irq_o}, 32'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'hFFFF_FFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_irq_async", {31'h0, irq_o}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; gpio_in = '0;
    tick(2);
    rst_n = 1'b1;
    for (int o = 0; o <= 8'h14; o += 4)
      rd_chk($sformatf("rst_read_%0h", o), 8'(o), (o == 8'h14) ? 32'(LR) : 32'h0);
    chk("rst_irq_after", {31'h0, irq_o}, 32'h0);

    // Debounce bypass: change before edge n appears at edge n+2
    bus_wr(8'h08, 32'h1);
    bus_wr(8'h04, 32'h1);
    gpio_in[0] = 1'b1;
    tick(2);
    rd_chk("byp_level_n1", 8'h00, 32'h0);
    chk("byp_irq_n1", {31'h0, irq_o}, 32'h0);
    tick(1);
    rd_chk("byp_level_n2", 8'h00, 32'h1);
    rd_chk("byp_pend_n2", 8'h10, 32'h1);
    chk("byp_irq_n2", {31'h0, irq_o}, 32'h1);

    // Debounce limit 4: a 4-cycle pulse is rejected, a held level lands at n+6
    bus_wr(8'h10, 32'hFFFF_FFFF);
    bus_wr(8'h08, 32'h9);
    bus_wr(8'h14, 32'h4);
    gpio_in[3] = 1'b1;
    tick(4);
    gpio_in[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      rd_chk("db_glitch_level", 8'h00, 32'h1);
    end
    rd_chk("db_glitch_pend", 8'h10, 32'h0);
    gpio_in[3] = 1'b1;
    tick(6);
    rd_chk("db_hold_n5", 8'h00, 32'h1);
    tick(1);
    rd_chk("db_hold_n6", 8'h00, 32'h9);
    rd_chk("db_hold_pend", 8'h10, 32'h8);

    // W1C racing a fall event on the same edge: set wins
    bus_wr(8'h14, 32'h0);
    bus_wr(8'h10, 32'hFFFF_FFFF);
    bus_wr(8'h08, 32'h20);
    bus_wr(8'h0C, 32'h20);
    bus_wr(8'h04, 32'h20);
    gpio_in[5] = 1'b1;
    tick(3);
    rd_chk("race_pre_pend", 8'h10, 32'h20);
    gpio_in[5] = 1'b0;
    tick(2);
    bus_wr(8'h10, 32'h20);
    rd_chk("race_level", 8'h00, 32'h9);
    rd_chk("race_pend", 8'h10, 32'h20);
    chk("race_irq", {31'h0, irq_o}, 32'h1);
    bus_wr(8'h10, 32'h20);
    rd_chk("race_clr_pend", 8'h10, 32'h0);
    chk("race_clr_irq", {31'h0, irq_o}, 32'h0);

    // Interrupt masking
    do_reset();
    bus_wr(8'h08, 32'h3);
    gpio_in[1:0] = 2'b11;
    tick(3);
    bus_wr(8'h04, 32'h2);
    chk("mask_irq_on", {31'h0, irq_o}, 32'h1);
    rd_chk("mask_pend", 8'h10, 32'h3);
    bus_wr(8'h04, 32'h0);
    chk("mask_irq_off", {31'h0, irq_o}, 32'h0);
    rd_chk("mask_pend_kept", 8'h10, 32'h3);
    rd_chk("unmapped_18", 8'h18, 32'h0);

    // DB_LIMIT rewrite restarts qualification
    bus_wr(8'h14, 32'd10);
    gpio_in[7] = 1'b1;
    tick(6);
    bus_wr(8'h14, 32'd10);
    tick(10);
    rd_chk("relim_w10", 8'h00, 32'h3);
    tick(1);
    rd_chk("relim_w11", 8'h00, 32'h83);

    // Randomised traffic against the reference model
    do_reset();
    model_reset();
    pad = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [7:0]  a;
      logic [31:0] d;
      bit          wr;
      int          r;
      bus_rd(8'h00, v);
      chk("rnd_level", v, 32'(m_stable));
      bus_rd(8'h10, v);
      chk("rnd_pend", v, 32'(m_pend));
      chk("rnd_irq", {31'h0, irq_o}, {31'h0, m_irq});
      for (int i = 0; i < W; i++)
        if ($urandom_range(7) == 0) pad[i] = ~pad[i];
      gpio_in = pad;
      r  = $urandom_range(11);
      wr = 1'b1;
      d  = $urandom;
      case (r)
        0: a = 8'h04;
        1: a = 8'h08;
        2: a = 8'h0C;
        3, 4: a = 8'h10;
        5: begin a = 8'h14; d = 32'($urandom_range(3)); end
        6: a = 8'h18;
        default: begin a = 8'h00; wr = 1'b0; end
      endcase
      model_step(pad, wr, a, d);
      if (wr) bus_wr(a, d);
      else    tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
